// File: rtl/instruction_buffer.sv
// Instruction prefetch FIFO: tracks outstanding bus reads, drops flushed returns, flags bus protocol errors.
// Optional macro INSTRUCTION_BUFFER_BYPASS_EN: presents a return beat combinationally when the FIFO is empty.
module instruction_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        issue,
  input  logic        flush,
  input  logic [31:0] system_bus_read_data,
  input  logic        system_bus_read_data_valid,
  output logic        issue_allowed,
  output logic [31:0] instruction,
  output logic        instruction_valid,
  input  logic        instruction_ready,
  output logic        protocol_error
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic          protocol_error_q, protocol_error_d;
  logic [31:0]   mem_q [DEPTH];

  logic [CW:0]   occupancy;
  logic          issue_ok;
  logic          beat_ok;
  logic          beat_unexpected;
  logic          beat_keep;
  logic          head_valid;
  logic          push;
  logic          pop;
  logic          bypass_take;
`ifdef INSTRUCTION_BUFFER_BYPASS_EN
  logic          bypass_hit;
`endif

  always_comb begin
    occupancy       = {1'b0, count_q} + {1'b0, outstanding_q};
    issue_allowed   = (occupancy < (CW + 1)'(DEPTH));
    issue_ok        = issue && issue_allowed;
    beat_ok         = system_bus_read_data_valid && (outstanding_q != '0);
    beat_unexpected = system_bus_read_data_valid && (outstanding_q == '0);
    // A beat survives only if no older flush still owns it and no flush is happening now.
    beat_keep       = beat_ok && !flush && (discard_q == '0);
    head_valid      = (count_q != '0);
    pop             = head_valid && instruction_ready && !flush;

`ifdef INSTRUCTION_BUFFER_BYPASS_EN
    bypass_hit        = beat_keep && !head_valid;
    bypass_take       = bypass_hit && instruction_ready;
    instruction_valid = head_valid || bypass_hit;
    if (head_valid) begin
      instruction = mem_q[rd_ptr_q];
    end else if (bypass_hit) begin
      instruction = system_bus_read_data;
    end else begin
      instruction = 32'h0;
    end
`else
    bypass_take       = 1'b0;
    instruction_valid = head_valid;
    instruction       = head_valid ? mem_q[rd_ptr_q] : 32'h0;
`endif

    push           = beat_keep && !bypass_take;
    protocol_error = protocol_error_q;

    outstanding_d    = outstanding_q + CW'(issue_ok) - CW'(beat_ok);
    protocol_error_d = protocol_error_q || beat_unexpected || (issue && !issue_allowed);

    if (flush) begin
      // Every read still in flight belongs to the old stream, except a beat retiring right now.
      count_d   = '0;
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      discard_d = outstanding_q - CW'(beat_ok);
    end else begin
      count_d   = count_q + CW'(push) - CW'(pop);
      rd_ptr_d  = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      wr_ptr_d  = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      discard_d = discard_q - CW'(beat_ok && (discard_q != '0));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q          <= '0;
      outstanding_q    <= '0;
      discard_q        <= '0;
      rd_ptr_q         <= '0;
      wr_ptr_q         <= '0;
      protocol_error_q <= 1'b0;
    end else begin
      count_q          <= count_d;
      outstanding_q    <= outstanding_d;
      discard_q        <= discard_d;
      rd_ptr_q         <= rd_ptr_d;
      wr_ptr_q         <= wr_ptr_d;
      protocol_error_q <= protocol_error_d;
    end
  end

  // Storage needs no reset: count_q gates every read of it.
  always_ff @(posedge clk) begin
    if (reset_n && push) begin
      mem_q[wr_ptr_q] <= system_bus_read_data;
    end
  end

endmodule
